// File: rtl/orbit_pkg.sv
// Shared types and constants for the Euler-step micro-sequencer:
// FP op codes, register/source indices, micro-op layout and FSM states.
package orbit_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MUL = 2'd1,
        OP_ISQ = 2'd2
    } opc_e;

    // Register file indices r0..r7
    localparam logic [2:0] R_X  = 3'd0;
    localparam logic [2:0] R_Y  = 3'd1;
    localparam logic [2:0] R_VX = 3'd2;
    localparam logic [2:0] R_VY = 3'd3;
    localparam logic [2:0] R_T0 = 3'd4;
    localparam logic [2:0] R_T1 = 3'd5;
    localparam logic [2:0] R_T2 = 3'd6;
    localparam logic [2:0] R_T3 = 3'd7;

    // Operand sources: 0..7 select a register, 8..10 select a constant
    localparam logic [3:0] S_X    = 4'd0;
    localparam logic [3:0] S_Y    = 4'd1;
    localparam logic [3:0] S_VX   = 4'd2;
    localparam logic [3:0] S_VY   = 4'd3;
    localparam logic [3:0] S_T0   = 4'd4;
    localparam logic [3:0] S_T1   = 4'd5;
    localparam logic [3:0] S_T2   = 4'd6;
    localparam logic [3:0] S_T3   = 4'd7;
    localparam logic [3:0] S_KG   = 4'd8;
    localparam logic [3:0] S_KDT  = 4'd9;
    localparam logic [3:0] S_ZERO = 4'd10;

    localparam int unsigned PROG_LEN = 15;
    localparam logic [3:0]  PC_LAST  = 4'(PROG_LEN - 1);

    localparam logic [31:0] K_GMDT_DEF = 32'hBC23D70A;
    localparam logic [31:0] K_DT_DEF   = 32'h3C23D70A;

    typedef struct packed {
        opc_e       opc;
        logic [2:0] dst;
        logic [3:0] srca;
        logic [3:0] srcb;
    } uop_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_STEP_END,
        ST_DONE,
        ST_ERROR
    } state_e;

    function automatic uop_t mk_uop(input opc_e o, input logic [2:0] d,
                                    input logic [3:0] a, input logic [3:0] b);
        uop_t u;
        u.opc  = o;
        u.dst  = d;
        u.srca = a;
        u.srcb = b;
        return u;
    endfunction

endpackage

// File: rtl/euler_uop_rom.sv
// Fixed 15-entry micro-program for one semi-implicit Euler step.
module euler_uop_rom
    import orbit_pkg::*;
(
    input  logic [3:0] pc,
    output uop_t       uop
);

    always_comb begin
        case (pc)
            4'd0:    uop = mk_uop(OP_MUL, R_T0, S_X,  S_X);
            4'd1:    uop = mk_uop(OP_MUL, R_T1, S_Y,  S_Y);
            4'd2:    uop = mk_uop(OP_ADD, R_T0, S_T0, S_T1);
            4'd3:    uop = mk_uop(OP_ISQ, R_T1, S_T0, S_ZERO);
            4'd4:    uop = mk_uop(OP_MUL, R_T2, S_T1, S_T1);
            4'd5:    uop = mk_uop(OP_MUL, R_T2, S_T2, S_T1);
            4'd6:    uop = mk_uop(OP_MUL, R_T2, S_T2, S_KG);
            4'd7:    uop = mk_uop(OP_MUL, R_T3, S_X,  S_T2);
            4'd8:    uop = mk_uop(OP_ADD, R_VX, S_VX, S_T3);
            4'd9:    uop = mk_uop(OP_MUL, R_T3, S_Y,  S_T2);
            4'd10:   uop = mk_uop(OP_ADD, R_VY, S_VY, S_T3);
            4'd11:   uop = mk_uop(OP_MUL, R_T3, S_VX, S_KDT);
            4'd12:   uop = mk_uop(OP_ADD, R_X,  S_X,  S_T3);
            4'd13:   uop = mk_uop(OP_MUL, R_T3, S_VY, S_KDT);
            4'd14:   uop = mk_uop(OP_ADD, R_Y,  S_Y,  S_T3);
            default: uop = '0;
        endcase
    end

endmodule

// File: rtl/euler_step_sequencer.sv
// Drives a shared FP unit through the Euler micro-program, one position
// sample per step, with a per-op result timeout.
module euler_step_sequencer
    import orbit_pkg::*;
#(
    parameter logic [31:0] K_GMDT  = K_GMDT_DEF,
    parameter logic [31:0] K_DT    = K_DT_DEF,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] vx0,
    input  logic [31:0] vy0,
    input  logic [15:0] n_steps,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [1:0]  op_code,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        res_valid,
    input  logic [31:0] res,
    output logic [31:0] X,
    output logic [31:0] Y,
    output logic        sample_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned WCW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [3:0]        pc_q, pc_d;
    logic [15:0]       step_cnt_q, step_cnt_d;
    logic [15:0]       n_steps_q, n_steps_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [7:0][31:0]  rf_q, rf_d;
    logic [31:0]       x_q, x_d, y_q, y_d;
    logic              sample_valid_q, sample_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    uop_t              uop;

    euler_uop_rom u_rom (
        .pc  (pc_q),
        .uop (uop)
    );

    function automatic logic [31:0] src_val(input logic [3:0] s, input logic [7:0][31:0] rf);
        case (s)
            S_KG:    return K_GMDT;
            S_KDT:   return K_DT;
            default: return s[3] ? 32'd0 : rf[s[2:0]];
        endcase
    endfunction

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        step_cnt_d     = step_cnt_q;
        n_steps_d      = n_steps_q;
        wait_cnt_d     = wait_cnt_q;
        rf_d           = rf_q;
        x_d            = x_q;
        y_d            = y_q;
        sample_valid_d = 1'b0;
        done_d         = 1'b0;
        err_d          = err_q;

        case (state_q)
            ST_IDLE: begin
                // Inputs are captured on the start edge itself so they need
                // only be valid alongside the start pulse.
                if (start) begin
                    rf_d[R_X]  = x0;
                    rf_d[R_Y]  = y0;
                    rf_d[R_VX] = vx0;
                    rf_d[R_VY] = vy0;
                    n_steps_d  = n_steps;
                    err_d      = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                x_d        = rf_q[R_X];
                y_d        = rf_q[R_Y];
                pc_d       = '0;
                step_cnt_d = '0;
                if (n_steps_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_ready) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (res_valid) begin
                    rf_d[uop.dst] = res;
                    if (pc_q == PC_LAST) begin
                        // Sample from the post-write file so Y includes this result.
                        x_d            = rf_d[R_X];
                        y_d            = rf_d[R_Y];
                        sample_valid_d = 1'b1;
                        state_d        = ST_STEP_END;
                    end else begin
                        pc_d    = pc_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end else if (wait_cnt_q == WCW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_STEP_END: begin
                step_cnt_d = step_cnt_q + 16'd1;
                if (({1'b0, step_cnt_q} + 17'd1) == {1'b0, n_steps_q}) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    pc_d    = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= '0;
            step_cnt_q     <= '0;
            n_steps_q      <= '0;
            wait_cnt_q     <= '0;
            rf_q           <= '0;
            x_q            <= '0;
            y_q            <= '0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            step_cnt_q     <= step_cnt_d;
            n_steps_q      <= n_steps_d;
            wait_cnt_q     <= wait_cnt_d;
            rf_q           <= rf_d;
            x_q            <= x_d;
            y_q            <= y_d;
            sample_valid_q <= sample_valid_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        op_code = '0;
        op_a    = '0;
        op_b    = '0;
        if (state_q == ST_ISSUE) begin
            op_code = uop.opc;
            op_a    = src_val(uop.srca, rf_q);
            op_b    = src_val(uop.srcb, rf_q);
        end
    end

    assign op_valid     = (state_q == ST_ISSUE);
    assign busy         = (state_q != ST_IDLE);
    assign X            = x_q;
    assign Y            = y_q;
    assign sample_valid = sample_valid_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_euler_step_sequencer.sv
// Directed bench for euler_step_sequencer with an ideal zero-latency FP unit
// model built on double-precision reals rounded to single.
module tb_euler_step_sequencer;

    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] KG   = 32'hBC23D70A;
    localparam logic [31:0] KDT  = 32'h3C23D70A;
    localparam int          TOUT = 64;
    localparam logic [1:0]  EXP_OPC [15] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1,
                                             2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] x0, y0, vx0, vy0;
    logic [15:0] n_steps;
    logic        op_valid, op_ready;
    logic [1:0]  op_code;
    logic [31:0] op_a, op_b;
    logic        res_valid;
    logic [31:0] res;
    logic [31:0] X, Y;
    logic        sample_valid, busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;
    int samples = 0;
    int cyc     = 0;
    int last_sample_cyc = 0;
    int step_period = 0;
    bit hung = 1'b0;

    euler_step_sequencer #(.K_GMDT(KG), .K_DT(KDT), .TIMEOUT(TOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .x0           (x0),
        .y0           (y0),
        .vx0          (vx0),
        .vy0          (vy0),
        .n_steps      (n_steps),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .op_a         (op_a),
        .op_b         (op_b),
        .res_valid    (res_valid),
        .res          (res),
        .X            (X),
        .Y            (Y),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] f2d(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return {f[31], 63'd0};
        e = 11'(f[30:23]) + 11'd896;
        return {f[31], e, f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        int          ef;
        logic        rnd;
        logic [31:0] r;
        ef = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || ef <= 0) return {d[63], 31'd0};
        if (ef >= 255) return {d[63], 8'hFF, 23'd0};
        rnd = d[28] && ((|d[27:0]) || d[29]);
        r = {1'b0, ef[7:0], d[51:29]};
        r = r + {31'd0, rnd};
        r[31] = d[63];
        return r;
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return d2f($realtobits($bitstoreal(f2d(a)) + $bitstoreal(f2d(b))));
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return d2f($realtobits($bitstoreal(f2d(a)) * $bitstoreal(f2d(b))));
    endfunction

    function automatic logic [31:0] fisq(input logic [31:0] a);
        return d2f($realtobits(1.0 / $sqrt($bitstoreal(f2d(a)))));
    endfunction

    function automatic logic [31:0] fp_unit(input logic [1:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            2'd0:    return fadd(a, b);
            2'd1:    return fmul(a, b);
            2'd2:    return fisq(a);
            default: return 32'h7FC00000;
        endcase
    endfunction

    // Reference step written directly from the integration formulas
    task automatic ref_step(inout logic [31:0] x, inout logic [31:0] y,
                            inout logic [31:0] vx, inout logic [31:0] vy);
        logic [31:0] r2, ir, k;
        r2 = fadd(fmul(x, x), fmul(y, y));
        ir = fisq(r2);
        k  = fmul(fmul(fmul(ir, ir), ir), KG);
        vx = fadd(vx, fmul(x, k));
        vy = fadd(vy, fmul(y, k));
        x  = fadd(x, fmul(vx, KDT));
        y  = fadd(y, fmul(vy, KDT));
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve_op(input int hold, input bit noise, input int pcx);
        int          n;
        logic [1:0]  c;
        logic [31:0] a, b;
        if (hung) return;
        n = 0;
        while (op_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("op_valid_arrives", op_valid, 1'b1);
        if (op_valid !== 1'b1) begin
            hung = 1'b1;
            return;
        end
        c = op_code;
        a = op_a;
        b = op_b;
        chk($sformatf("opcode_pc%0d", pcx), c, EXP_OPC[pcx]);
        if (c == 2'd2) chk("isq_b_zero", b, 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                start     = 1'b1;
                x0        = 32'hDEADBEEF;
                n_steps   = 16'd1;
                res_valid = 1'b1;
                res       = 32'hBAADF00D;
            end
            @(negedge clk);
            chk("hold_stable", {op_valid, op_code, op_a, op_b}, {1'b1, c, a, b});
        end
        start     = 1'b0;
        res_valid = 1'b0;
        res       = '0;
        op_ready  = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("single_issue", op_valid, 1'b0);
        res       = fp_unit(c, a, b);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        res       = '0;
    endtask

    task automatic run_step(input int hold_pc, input int hold, input bit noise);
        for (int pc = 0; pc < 15; pc++) serve_op((pc == hold_pc) ? hold : 0, noise, pc);
        chk("sample_valid", sample_valid, 1'b1);
        if (sample_valid === 1'b1) begin
            samples++;
            step_period     = cyc - last_sample_cyc;
            last_sample_cyc = cyc;
        end
    endtask

    task automatic pulse_start(input logic [31:0] xi, input logic [31:0] yi,
                               input logic [31:0] vxi, input logic [31:0] vyi,
                               input logic [15:0] n);
        x0 = xi; y0 = yi; vx0 = vxi; vy0 = vyi; n_steps = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] rx, ry, rvx, rvy;
        int          waited;
        bit          saw_done;

        rst_n = 1'b0; start = 1'b0; op_ready = 1'b0; res_valid = 1'b0; res = '0;
        x0 = '0; y0 = '0; vx0 = '0; vy0 = '0; n_steps = '0;
        repeat (3) @(negedge clk);
        chk("rst_ops", {op_valid, op_code, op_a, op_b}, '0);
        chk("rst_xy", {X, Y}, '0);
        chk("rst_flags", {sample_valid, busy, done, err}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {busy, op_valid}, '0);

        // Single step from (1,0) with velocity (0,1)
        pulse_start(ONE, 32'd0, 32'd0, ONE, 16'd1);
        chk("load_cycle", {busy, op_valid}, 2'b10);
        @(negedge clk);
        chk("first_issue", {op_valid, op_code, op_a, op_b}, {1'b1, 2'd1, ONE, ONE});
        rx = ONE; ry = 32'd0; rvx = 32'd0; rvy = ONE;
        ref_step(rx, ry, rvx, rvy);
        run_step(-1, 0, 1'b0);
        chk("t1_x", X, rx);
        chk("t1_y", Y, 32'h3C23D70A);
        @(negedge clk);
        chk("t1_done", {done, sample_valid, busy}, 3'b101);
        @(negedge clk);
        chk("t1_idle", {done, busy}, 2'b00);
        chk("t1_one_sample", samples, 1);

        // Zero steps: straight to done, position is the initial state
        pulse_start(32'h40490FDB, 32'hC0000000, ONE, ONE, 16'd0);
        chk("n0_load", {done, op_valid, busy}, 3'b001);
        @(negedge clk);
        chk("n0_done", {done, op_valid}, 2'b10);
        chk("n0_xy", {X, Y}, {32'h40490FDB, 32'hC0000000});
        @(negedge clk);
        chk("n0_idle", {done, busy}, 2'b00);

        // Two steps with op_ready stalls; second stall carries start and res_valid noise
        pulse_start(ONE, 32'd0, 32'd0, ONE, 16'd2);
        rx = ONE; ry = 32'd0; rvx = 32'd0; rvy = ONE;
        ref_step(rx, ry, rvx, rvy);
        run_step(3, 5, 1'b0);
        chk("t3_x1", X, rx);
        chk("t3_y1", Y, ry);
        ref_step(rx, ry, rvx, rvy);
        run_step(7, 3, 1'b1);
        chk("t3_x2", X, rx);
        chk("t3_y2", Y, ry);
        @(negedge clk);
        chk("t3_done", done, 1'b1);

        // Timeout: accept the first op and never return a result
        @(negedge clk);
        pulse_start(ONE, 32'h40000000, 32'd0, ONE, 16'd3);
        @(negedge clk);
        chk("to_issue", op_valid, 1'b1);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        waited = 0;
        saw_done = 1'b0;
        while (err !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("to_latency", waited, TOUT + 1);
        chk("to_err_state", {err, busy, saw_done}, 3'b110);
        @(negedge clk);
        chk("to_idle", {err, busy, done, op_valid}, 4'b1000);
        chk("to_xy_kept", {X, Y}, {ONE, 32'h40000000});
        pulse_start(ONE, ONE, ONE, ONE, 16'd0);
        chk("to_err_cleared", err, 1'b0);
        @(negedge clk);
        chk("to_restart_done", done, 1'b1);
        @(negedge clk);

        // Reset mid-run, then a full 100-step run
        pulse_start(ONE, 32'd0, 32'd0, ONE, 16'd100);
        run_step(-1, 0, 1'b0);
        for (int pc = 0; pc < 3; pc++) serve_op(0, 1'b0, pc);
        chk("pre_rst_active", {op_valid, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ops", {op_valid, op_code, op_a, op_b}, '0);
        chk("mid_rst_xy", {X, Y}, '0);
        chk("mid_rst_flags", {sample_valid, busy, done, err}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        samples = 0;
        pulse_start(ONE, 32'd0, 32'd0, ONE, 16'd100);
        rx = ONE; ry = 32'd0; rvx = 32'd0; rvy = ONE;
        for (int s = 0; s < 100; s++) begin
            ref_step(rx, ry, rvx, rvy);
            run_step(-1, 0, 1'b0);
        end
        chk("r100_samples", samples, 100);
        chk("r100_period", step_period, 31);
        chk("r100_x", X, rx);
        chk("r100_y", Y, ry);
        @(negedge clk);
        chk("r100_done", {done, busy}, 2'b11);
        @(negedge clk);
        chk("r100_idle", {done, busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
